rtc_rgs_mc: RTL and testbench

Next-generation RTC software register block, parametrised for NUM_CH external event timestamp capture channels.
- Adds an atomic snapshot of current-time reads.
- Adds per-channel capture registers with valid/overflow status (W1C), interrupt enable and a level interrupt.
- Sits between the 32-bit on-chip bus and the RTC core / event timestampers.
- Drives the RTC offset/tick/PPS controls.

---
 rtl/rtc_rgs_mc_pkg.sv | 58 +++++
 rtl/rtc_evt_cap.sv | 72 +++++++
 rtl/rtc_rgs_mc.sv | 177 +++++++++++++++++
 tb/tb_rtc_rgs_mc.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_rgs_mc_pkg.sv
// Register map constants, CTL bit indices and timestamp word packing for rtc_rgs_mc.
package rtc_rgs_mc_pkg;

    // Word offsets within the 256-byte block
    localparam logic [7:0] OFF_CTL      = 8'h00;
    localparam logic [7:0] OFF_TICK_INC = 8'h04;
    localparam logic [7:0] OFF_NS_OFST  = 8'h08;
    localparam logic [7:0] OFF_SC_OFST0 = 8'h0C;
    localparam logic [7:0] OFF_SC_OFST1 = 8'h10;
    localparam logic [7:0] OFF_CUR_TM0  = 8'h14;
    localparam logic [7:0] OFF_CUR_TM1  = 8'h18;
    localparam logic [7:0] OFF_CUR_TM2  = 8'h1C;
    localparam logic [7:0] OFF_PPS_W    = 8'h20;
    localparam logic [7:0] OFF_EVT_STS  = 8'h24;
    localparam logic [7:0] OFF_EVT_IEN  = 8'h28;

    // Per-channel capture window: base + stride * channel + word
    localparam int unsigned CH_BASE   = 'h40;
    localparam int unsigned CH_STRIDE = 'h10;
    localparam int unsigned OFF_TS0   = 'h0;
    localparam int unsigned OFF_TS1   = 'h4;
    localparam int unsigned OFF_TS2   = 'h8;

    localparam int unsigned MAX_CH = 8;

    // CTL bit positions
    localparam int unsigned CTL_OFFSET_VALID = 0;
    localparam int unsigned CTL_CLEAR_RTC    = 1;
    localparam int unsigned CTL_INTXMS_SEL   = 2;

    // EVT_STS / EVT_IEN: valid flags in the low byte, overflow flags from this bit up
    localparam int unsigned STS_OVF_LSB = 8;

    typedef enum logic [1:0] {
        TsWord0,
        TsWord1,
        TsWord2
    } ts_word_e;

    // Split an {sec[47:0], ns[31:0]} time plus fractional ns into one of three bus words
    function automatic logic [31:0] ts_word(input logic [79:0] std, input logic [15:0] fns,
                                            input ts_word_e sel);
        logic [31:0] word;
        case (sel)
            TsWord0: word = std[79:48];
            TsWord1: word = std[47:16];
            TsWord2: word = {std[15:0], fns};
            default: word = '0;
        endcase
        return word;
    endfunction

    // Offset of timestamp word 'word' for channel 'ch'
    function automatic logic [7:0] ch_off(input int unsigned ch, input int unsigned word);
        return 8'(CH_BASE + CH_STRIDE * ch + word);
    endfunction

endpackage

// File: rtl/rtc_evt_cap.sv
// One event-timestamp capture channel: TS register, valid/overflow flags and the
// arbitration between a new strobe, a TS2 release read and a W1C status clear.
module rtc_evt_cap
    import rtc_rgs_mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic [79:0] evt_std,
    input  logic [15:0] evt_fns,
    input  logic        rel,
    input  logic        clr_valid,
    input  logic        clr_ovf,
    output logic [79:0] ts_std,
    output logic [15:0] ts_fns,
    output logic        valid,
    output logic        ovf
);

    logic [79:0] std_q;
    logic [15:0] fns_q;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;
    logic        load;
    logic        ovf_set;

    // Next-state: a release in the same cycle frees the slot for the new strobe;
    // any strobe counts as a set and beats a W1C clear.
    always_comb begin
        load    = stb && (!valid_q || rel);
        ovf_set = stb && valid_q && !rel;

        valid_d = valid_q;
        if (rel || clr_valid) begin
            valid_d = 1'b0;
        end
        if (stb) begin
            valid_d = 1'b1;
        end

        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // Capture state register
    always_ff @(posedge clk) begin
        if (rst) begin
            std_q   <= '0;
            fns_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            if (load) begin
                std_q <= evt_std;
                fns_q <= evt_fns;
            end
        end
    end

    assign ts_std = std_q;
    assign ts_fns = fns_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/rtc_rgs_mc.sv
// RTC software register block: RTC control registers, atomic current-time snapshot
// and NUM_CH event timestamp capture channels with a level interrupt.
module rtc_rgs_mc
    import rtc_rgs_mc_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter logic [23:0] BLK_ADDR = 24'h000100
) (
    input  logic                   bus2ip_clk,
    input  logic                   bus2ip_rst,
    input  logic [31:0]            bus2ip_addr_i,
    input  logic [31:0]            bus2ip_data_i,
    input  logic                   bus2ip_rd_ce_i,
    input  logic                   bus2ip_wr_ce_i,
    output logic [31:0]            ip2bus_data_o,
    input  logic [79:0]            rtc_std_i,
    input  logic [15:0]            rtc_fns_i,
    input  logic [NUM_CH-1:0]      evt_stb_i,
    input  logic [80*NUM_CH-1:0]   evt_std_i,
    input  logic [16*NUM_CH-1:0]   evt_fns_i,
    output logic [31:0]            tick_inc_o,
    output logic [31:0]            ns_offset_o,
    output logic [47:0]            sc_offset_o,
    output logic                   offset_valid_o,
    output logic                   clear_rtc_o,
    output logic [31:0]            pps_width_o,
    output logic                   intxms_sel_o,
    output logic                   irq_o
);

    localparam logic [7:0]  CH_MASK  = 8'((1 << NUM_CH) - 1);
    localparam logic [15:0] STS_MASK = {CH_MASK, CH_MASK};

    logic        hit;
    logic [7:0]  off;
    logic        rd_hit;
    logic        wr_hit;
    logic        sts_wr;

    logic [31:0] tick_inc_q;
    logic [31:0] ns_ofst_q;
    logic [31:0] pps_w_q;
    logic [47:0] sc_ofst_q;
    logic        intxms_q;
    logic        offset_valid_q;
    logic        clear_rtc_q;
    logic [63:0] snap_q;       // {sec[15:0], ns[31:0], fns[15:0]} latched on CUR_TM0 read
    logic [15:0] ien_q;
    logic [31:0] rdata_q;
    logic        irq_q;

    logic [31:0] rd_word;
    logic [7:0]  ch_valid;
    logic [7:0]  ch_ovf;
    logic [15:0] sts;

    logic [79:0] ts_std [NUM_CH];
    logic [15:0] ts_fns [NUM_CH];

    assign hit    = (bus2ip_addr_i[31:8] == BLK_ADDR);
    assign off    = bus2ip_addr_i[7:0];
    assign rd_hit = bus2ip_rd_ce_i && hit;
    assign wr_hit = bus2ip_wr_ce_i && hit;
    assign sts_wr = wr_hit && (off == OFF_EVT_STS);
    assign sts    = {ch_ovf, ch_valid};

    // Capture channels; unused channel slots read back as zero
    for (genvar c = 0; c < MAX_CH; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            logic rel;
            assign rel = rd_hit && (off == ch_off(c, OFF_TS2));

            rtc_evt_cap u_cap (
                .clk       (bus2ip_clk),
                .rst       (bus2ip_rst),
                .stb       (evt_stb_i[c]),
                .evt_std   (evt_std_i[80*c +: 80]),
                .evt_fns   (evt_fns_i[16*c +: 16]),
                .rel       (rel),
                .clr_valid (sts_wr && bus2ip_data_i[c]),
                .clr_ovf   (sts_wr && bus2ip_data_i[STS_OVF_LSB + c]),
                .ts_std    (ts_std[c]),
                .ts_fns    (ts_fns[c]),
                .valid     (ch_valid[c]),
                .ovf       (ch_ovf[c])
            );
        end else begin : g_off
            assign ch_valid[c] = 1'b0;
            assign ch_ovf[c]   = 1'b0;
        end
    end

    // Read data mux for the addressed word
    always_comb begin
        rd_word = '0;
        case (off)
            OFF_CTL:      rd_word[CTL_INTXMS_SEL] = intxms_q;
            OFF_TICK_INC: rd_word = tick_inc_q;
            OFF_NS_OFST:  rd_word = ns_ofst_q;
            OFF_SC_OFST0: rd_word = {16'h0000, sc_ofst_q[47:32]};
            OFF_SC_OFST1: rd_word = sc_ofst_q[31:0];
            OFF_CUR_TM0:  rd_word = ts_word(rtc_std_i, rtc_fns_i, TsWord0);
            OFF_CUR_TM1:  rd_word = snap_q[63:32];
            OFF_CUR_TM2:  rd_word = snap_q[31:0];
            OFF_PPS_W:    rd_word = pps_w_q;
            OFF_EVT_STS:  rd_word = {16'h0000, sts};
            OFF_EVT_IEN:  rd_word = {16'h0000, ien_q};
            default:      rd_word = '0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (off == ch_off(c, OFF_TS0)) begin
                rd_word = ts_word(ts_std[c], ts_fns[c], TsWord0);
            end
            if (off == ch_off(c, OFF_TS1)) begin
                rd_word = ts_word(ts_std[c], ts_fns[c], TsWord1);
            end
            if (off == ch_off(c, OFF_TS2)) begin
                rd_word = ts_word(ts_std[c], ts_fns[c], TsWord2);
            end
        end
    end

    // Control registers, snapshot, read data and interrupt
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            tick_inc_q     <= '0;
            ns_ofst_q      <= '0;
            pps_w_q        <= '0;
            sc_ofst_q      <= '0;
            intxms_q       <= 1'b0;
            offset_valid_q <= 1'b0;
            clear_rtc_q    <= 1'b0;
            snap_q         <= '0;
            ien_q          <= '0;
            rdata_q        <= '0;
            irq_q          <= 1'b0;
        end else begin
            offset_valid_q <= wr_hit && (off == OFF_CTL) && bus2ip_data_i[CTL_OFFSET_VALID];
            clear_rtc_q    <= wr_hit && (off == OFF_CTL) && bus2ip_data_i[CTL_CLEAR_RTC];

            if (wr_hit) begin
                case (off)
                    OFF_CTL:      intxms_q         <= bus2ip_data_i[CTL_INTXMS_SEL];
                    OFF_TICK_INC: tick_inc_q       <= bus2ip_data_i;
                    OFF_NS_OFST:  ns_ofst_q        <= bus2ip_data_i;
                    OFF_SC_OFST0: sc_ofst_q[47:32] <= bus2ip_data_i[15:0];
                    OFF_SC_OFST1: sc_ofst_q[31:0]  <= bus2ip_data_i;
                    OFF_PPS_W:    pps_w_q          <= bus2ip_data_i;
                    OFF_EVT_IEN:  ien_q            <= bus2ip_data_i[15:0] & STS_MASK;
                    default:      ;
                endcase
            end

            // Lower time fields are frozen with the CUR_TM0 read so CUR_TM1/2 stay coherent
            if (rd_hit && (off == OFF_CUR_TM0)) begin
                snap_q <= {rtc_std_i[47:0], rtc_fns_i};
            end

            if (bus2ip_rd_ce_i) begin
                rdata_q <= hit ? rd_word : 32'h0;
            end

            irq_q <= |(sts & ien_q);
        end
    end

    assign ip2bus_data_o  = rdata_q;
    assign tick_inc_o     = tick_inc_q;
    assign ns_offset_o    = ns_ofst_q;
    assign sc_offset_o    = sc_ofst_q;
    assign offset_valid_o = offset_valid_q;
    assign clear_rtc_o    = clear_rtc_q;
    assign pps_width_o    = pps_w_q;
    assign intxms_sel_o   = intxms_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_rtc_rgs_mc.sv
// Scoreboard bench for rtc_rgs_mc: a behavioural model predicts every read and every
// cycle's control outputs; a monitor pops and compares after each clock edge.
module tb_rtc_rgs_mc;

    localparam int NUM_CH = 2;
    localparam logic [23:0] BLK = 24'h000100;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [31:0]           addr, wdata;
    logic                  rd_ce, wr_ce;
    logic [31:0]           rdata;
    logic [79:0]           rtc_std;
    logic [15:0]           rtc_fns;
    logic [NUM_CH-1:0]     evt_stb;
    logic [80*NUM_CH-1:0]  evt_std;
    logic [16*NUM_CH-1:0]  evt_fns;
    logic [31:0]           tick_inc, ns_offset, pps_width;
    logic [47:0]           sc_offset;
    logic                  offset_valid, clear_rtc, intxms_sel, irq;

    rtc_rgs_mc #(.NUM_CH(NUM_CH), .BLK_ADDR(BLK)) dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst     (rst),
        .bus2ip_addr_i  (addr),
        .bus2ip_data_i  (wdata),
        .bus2ip_rd_ce_i (rd_ce),
        .bus2ip_wr_ce_i (wr_ce),
        .ip2bus_data_o  (rdata),
        .rtc_std_i      (rtc_std),
        .rtc_fns_i      (rtc_fns),
        .evt_stb_i      (evt_stb),
        .evt_std_i      (evt_std),
        .evt_fns_i      (evt_fns),
        .tick_inc_o     (tick_inc),
        .ns_offset_o    (ns_offset),
        .sc_offset_o    (sc_offset),
        .offset_valid_o (offset_valid),
        .clear_rtc_o    (clear_rtc),
        .pps_width_o    (pps_width),
        .intxms_sel_o   (intxms_sel),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        irq;
        logic        ov;
        logic        clr;
        logic        sel;
        logic [31:0] tick;
        logic [31:0] ns;
        logic [31:0] pps;
        logic [47:0] sc;
        logic [31:0] rdata;
    } outs_t;

    outs_t       oq[$];
    logic [31:0] rq[$];
    int          checks = 0;
    int          failures = 0;

    // Behavioural model state
    logic [31:0] m_tick, m_ns, m_pps, m_rdata;
    logic [47:0] m_sc;
    logic        m_sel;
    logic [15:0] m_snap_sec;
    logic [31:0] m_snap_ns;
    logic [15:0] m_snap_fns;
    logic [15:0] m_ien;
    logic        m_v [NUM_CH];
    logic        m_o [NUM_CH];
    logic [47:0] m_ts_sec [NUM_CH];
    logic [31:0] m_ts_ns  [NUM_CH];
    logic [15:0] m_ts_fns [NUM_CH];

    function automatic logic [31:0] pack3(logic [47:0] sec, logic [31:0] ns, logic [15:0] fns,
                                          int w);
        if (w == 0) return sec[47:16];
        if (w == 1) return {sec[15:0], ns[31:16]};
        return {ns[15:0], fns};
    endfunction

    function automatic logic [15:0] model_sts();
        logic [15:0] s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            s[c]     = m_v[c];
            s[8 + c] = m_o[c];
        end
        return s;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        int off;
        if (a[31:8] != BLK) return 32'h0;
        off = int'(a[7:0]);
        if (off >= 'h40 && off < 'h40 + 16 * NUM_CH) begin
            int c = (off - 'h40) / 16;
            int r = (off - 'h40) % 16;
            if (r == 0) return pack3(m_ts_sec[c], m_ts_ns[c], m_ts_fns[c], 0);
            if (r == 4) return pack3(m_ts_sec[c], m_ts_ns[c], m_ts_fns[c], 1);
            if (r == 8) return pack3(m_ts_sec[c], m_ts_ns[c], m_ts_fns[c], 2);
            return 32'h0;
        end
        case (off)
            'h00: return {29'h0, m_sel, 2'b00};
            'h04: return m_tick;
            'h08: return m_ns;
            'h0C: return {16'h0, m_sc[47:32]};
            'h10: return m_sc[31:0];
            'h14: return rtc_std[79:48];
            'h18: return {m_snap_sec, m_snap_ns[31:16]};
            'h1C: return {m_snap_ns[15:0], m_snap_fns};
            'h20: return m_pps;
            'h24: return {16'h0, model_sts()};
            'h28: return {16'h0, m_ien};
            default: return 32'h0;
        endcase
    endfunction

    // Predict the effect of the inputs currently applied, then let one clock pass
    task automatic step();
        outs_t o;
        logic  hit;
        int    off;
        if (rst) begin
            m_tick = 0; m_ns = 0; m_pps = 0; m_sc = 0; m_sel = 0; m_rdata = 0;
            m_snap_sec = 0; m_snap_ns = 0; m_snap_fns = 0; m_ien = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_v[c] = 0; m_o[c] = 0; m_ts_sec[c] = 0; m_ts_ns[c] = 0; m_ts_fns[c] = 0;
            end
            o = '0;
        end else begin
            hit = (addr[31:8] == BLK);
            off = int'(addr[7:0]);
            o.irq = |(model_sts() & m_ien);
            o.ov  = wr_ce && hit && off == 0 && wdata[0];
            o.clr = wr_ce && hit && off == 0 && wdata[1];
            if (rd_ce) begin
                m_rdata = model_read(addr);
                rq.push_back(m_rdata);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                logic        rel, w1c, was_v;
                logic [79:0] t;
                rel   = rd_ce && hit && off == 'h48 + 16 * c;
                w1c   = wr_ce && hit && off == 'h24;
                was_v = m_v[c];
                if (rel) m_v[c] = 0;
                if (w1c && wdata[c]) m_v[c] = 0;
                if (w1c && wdata[8 + c]) m_o[c] = 0;
                if (evt_stb[c]) begin
                    if (!was_v || rel) begin
                        t = evt_std[80 * c +: 80];
                        m_ts_sec[c] = t[79:32];
                        m_ts_ns[c]  = t[31:0];
                        m_ts_fns[c] = evt_fns[16 * c +: 16];
                    end else begin
                        m_o[c] = 1;
                    end
                    m_v[c] = 1;
                end
            end
            if (rd_ce && hit && off == 'h14) begin
                m_snap_sec = rtc_std[47:32];
                m_snap_ns  = rtc_std[31:0];
                m_snap_fns = rtc_fns;
            end
            if (wr_ce && hit) begin
                case (off)
                    'h00: m_sel = wdata[2];
                    'h04: m_tick = wdata;
                    'h08: m_ns = wdata;
                    'h0C: m_sc[47:32] = wdata[15:0];
                    'h10: m_sc[31:0] = wdata;
                    'h20: m_pps = wdata;
                    'h28: m_ien = wdata[15:0] & {8'(2 ** NUM_CH - 1), 8'(2 ** NUM_CH - 1)};
                    default: ;
                endcase
            end
        end
        o.sel = m_sel; o.tick = m_tick; o.ns = m_ns; o.pps = m_pps; o.sc = m_sc;
        o.rdata = m_rdata;
        oq.push_back(o);
        @(negedge clk);
    endtask

    task automatic cyc(logic r, logic w, logic [31:0] a, logic [31:0] d, logic [NUM_CH-1:0] s);
        rd_ce = r; wr_ce = w; addr = a; wdata = d; evt_stb = s;
        step();
    endtask

    task automatic rd(logic [7:0] o);
        cyc(1, 0, {BLK, o}, 32'h0, '0);
    endtask

    task automatic wr(logic [7:0] o, logic [31:0] d);
        cyc(0, 1, {BLK, o}, d, '0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0, '0);
    endtask

    task automatic rand_evt();
        for (int i = 0; i < 5 * NUM_CH; i++) evt_std[32 * i +: 32] = $urandom;
        for (int i = 0; i < NUM_CH; i++) evt_fns[16 * i +: 16] = 16'($urandom);
    endtask

    // Monitor: compare outputs presented after each active edge
    initial begin
        outs_t exp_o, act_o;
        logic  was_rd;
        logic [31:0] exp_r;
        forever begin
            @(posedge clk);
            was_rd = rd_ce && !rst;
            #1;
            if (oq.size() > 0) begin
                exp_o = oq.pop_front();
                act_o = {irq, offset_valid, clear_rtc, intxms_sel, tick_inc, ns_offset,
                         pps_width, sc_offset, rdata};
                checks++;
                if (act_o !== exp_o) begin
                    failures++;
                    $display("FAIL outs t=%0t act=%h exp=%h", $time, act_o, exp_o);
                end
            end
            if (was_rd) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL rd_queue_empty t=%0t act=%h exp=none", $time, rdata);
                end else begin
                    exp_r = rq.pop_front();
                    if (rdata !== exp_r) begin
                        failures++;
                        $display("FAIL rd_data t=%0t act=%h exp=%h", $time, rdata, exp_r);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1; rd_ce = 0; wr_ce = 0; addr = 0; wdata = 0; evt_stb = '0;
        rtc_std = '0; rtc_fns = '0; evt_std = '0; evt_fns = '0;
        @(negedge clk);
        idle(3);
        rst = 0;

        // Reset values on every offset, plus a non-hit read
        for (int o = 0; o < 'hC0; o += 4) rd(8'(o));
        cyc(1, 0, 32'h0000_0214, 32'h0, '0);

        // CTL pulses and readback
        wr(8'h00, 32'h3);
        idle(1);
        rd(8'h00);
        wr(8'h00, 32'h4);
        rd(8'h00);

        // Atomic snapshot
        rtc_std = 80'h000000000001_3B9AC9FF;
        rtc_fns = 16'hABCD;
        rd(8'h14);
        rtc_std = 80'h123456789ABC_DEADBEEF;
        rtc_fns = 16'h5555;
        rd(8'h18);
        rd(8'h1C);
        rd(8'h14);

        // Capture + interrupt + release on ch0
        wr(8'h28, 32'h1);
        rand_evt();
        cyc(0, 0, 32'h0, 32'h0, 2'b01);
        idle(2);
        rd(8'h24);
        rd(8'h40); rd(8'h44); rd(8'h48);
        idle(2);
        rd(8'h24);

        // Overflow on ch1 and W1C of the overflow bit only
        rand_evt();
        cyc(0, 0, 32'h0, 32'h0, 2'b10);
        rand_evt();
        cyc(0, 0, 32'h0, 32'h0, 2'b10);
        rd(8'h24);
        wr(8'h24, 32'h200);
        rd(8'h24);
        rd(8'h50); rd(8'h54); rd(8'h58);

        // Strobe coinciding with a TS2 release read on ch0
        rand_evt();
        cyc(0, 0, 32'h0, 32'h0, 2'b01);
        rand_evt();
        cyc(1, 0, {BLK, 8'h48}, 32'h0, 2'b01);
        rd(8'h24);
        rd(8'h40); rd(8'h48);

        // Strobe coinciding with a W1C of the same valid bit
        rand_evt();
        cyc(0, 1, {BLK, 8'h24}, 32'h101, 2'b01);
        rd(8'h24);

        // Reset cancels a pending pulse and captured data
        wr(8'h28, 32'hFFFF);
        rst = 1;
        cyc(0, 1, {BLK, 8'h00}, 32'h3, 2'b11);
        rst = 0;
        rd(8'h24); rd(8'h28); rd(8'h40);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned k;
            logic [31:0] a, d;
            logic [NUM_CH-1:0] s;
            rtc_std = 80'({$urandom, $urandom, $urandom});
            rtc_fns = 16'($urandom);
            rand_evt();
            for (int c = 0; c < NUM_CH; c++) s[c] = ($urandom_range(0, 5) == 0);
            k = $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0) a = {24'($urandom), 8'($urandom_range(0, 63) * 4)};
            else a = {BLK, 8'($urandom_range(0, 47) * 4)};
            d = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1;
                cyc(0, 0, 32'h0, 32'h0, s);
                rst = 0;
            end else if (k < 4) begin
                cyc(1, 0, a, 32'h0, s);
            end else if (k < 6) begin
                cyc(0, 1, a, d, s);
            end else begin
                cyc(0, 0, 32'h0, 32'h0, s);
            end
        end

        idle(3);
        checks++;
        if (rq.size() != 0 || oq.size() != 0) begin
            failures++;
            $display("FAIL drain act=%0d/%0d exp=0/0", rq.size(), oq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
